questao9_solver: RTL and testbench

Sequential inverse of the questao9 gate network: sweeps every combination of the two 3-bit operands, evaluates the per-bit OR / NAND / NOR + AND-reduce function and streams out each operand pair for which `Saida` = 1. Sits beside the combinational exercise blocks as a self-checking stimulus/solution generator for the board demo and the regression bench.

---
 rtl/questao9_pkg.sv | 16 +
 rtl/questao9_eval.sv | 15 +
 rtl/questao9_solver.sv | 121 ++++++++++++
 tb/tb_questao9_solver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/questao9_pkg.sv
// questao9 solver shared types and constants.
// State encoding, index/operand widths, full-sweep solution count.
package questao9_pkg;

  localparam int IDX_W      = 6;
  localparam int OP_W       = 3;
  localparam int N_SOL_FULL = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/questao9_eval.sv
// questao9 gate network, purely combinational.
// Ports: A[3:1], B[3:1] operands in; match out (Saida).
module questao9_eval
  import questao9_pkg::*;
(
  input  logic [OP_W:1] A,
  input  logic [OP_W:1] B,
  output logic          match
);

  assign match = (A[1] | B[1])
               & ~(A[2] & B[2])
               & ~(A[3] | B[3]);

endmodule

// File: rtl/questao9_solver.sv
// questao9 solver: sweeps idx 0..LAST_IDX, streams matching A/B pairs.
// Ports: clk, rst_n, start, ready in; A, B, valid, busy, done, total out.
// Optional QSOLVER_COUNT_EN builds the solution counter on total.
module questao9_solver
  import questao9_pkg::*;
#(
  parameter int unsigned LAST_IDX = 63
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [OP_W:1] A,
  output logic [OP_W:1] B,
  output logic          valid,
  input  logic          ready,
  output logic          busy,
  output logic          done,
  output logic [3:0]    total
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [OP_W:1]    a_q;
  logic [OP_W:1]    b_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             hit;
  logic             last;

  questao9_eval u_eval (
    .A     (idx_q[5:3]),
    .B     (idx_q[2:0]),
    .match (hit)
  );

  assign last = (idx_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (hit) begin
            a_q     <= idx_q[5:3];
            b_q     <= idx_q[2:0];
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 6'd1;
          end
        end
        HOLD: begin
          if (valid_q && ready) begin
            valid_q <= 1'b0;
            if (last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + 6'd1;
              state_q <= SCAN;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef QSOLVER_COUNT_EN
  logic [3:0] total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
    end else if (state_q == IDLE && start) begin
      total_q <= '0;
    end else if (state_q == HOLD && valid_q && ready) begin
      total_q <= total_q + 4'd1;
    end
  end

  assign total = total_q;
`else
  assign total = 4'd0;
`endif

endmodule

// File: tb/tb_questao9_solver.sv
// questao9 solver bench: random ready/start against a pair-list model.
// Covers reset, latency, stall, mid-sweep reset, short sweeps.
module tb_questao9_solver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ready;
  logic [3:1] A;
  logic [3:1] B;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] total;

  logic       st25, st7;
  logic       rdy_hi = 1'b1;
  logic [3:1] a25, b25, a7, b7;
  logic       v25, bz25, d25, v7, bz7, d7;
  logic [3:0] t25, t7;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  questao9_solver #(.LAST_IDX(63)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A(A), .B(B), .valid(valid), .ready(ready),
    .busy(busy), .done(done), .total(total)
  );

  questao9_solver #(.LAST_IDX(25)) dut25 (
    .clk(clk), .rst_n(rst_n), .start(st25),
    .A(a25), .B(b25), .valid(v25), .ready(rdy_hi),
    .busy(bz25), .done(d25), .total(t25)
  );

  questao9_solver #(.LAST_IDX(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .start(st7),
    .A(a7), .B(b7), .valid(v7), .ready(rdy_hi),
    .busy(bz7), .done(d7), .total(t7)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected solutions as {A,B} in sweep order, straight from the
  // operand rules: no bit 3 set, an odd operand, not both >= 2.
  function automatic void model(input int lst,
                                output logic [5:0] q[$]);
    int a, b;
    q.delete();
    for (int i = 0; i <= lst; i++) begin
      a = i / 8;
      b = i % 8;
      if (a < 4 && b < 4 && (a % 2 == 1 || b % 2 == 1)
          && !(a >= 2 && b >= 2))
        q.push_back(6'(a * 8 + b));
    end
  endfunction

  function automatic logic [3:0] exp_total(input int n);
`ifdef QSOLVER_COUNT_EN
    return 4'(n);
`else
    return 4'd0;
`endif
  endfunction

  task automatic compare(input string tag,
                         input logic [5:0] got[$],
                         input int lst,
                         input logic [3:0] tot);
    logic [5:0] exp_q[$];
    model(lst, exp_q);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_sol%0d", tag, i), got[i], exp_q[i]);
    chk({tag, "_total"}, tot, exp_total(exp_q.size()));
  endtask

  // Runs the main DUT to its done pulse, logging every handshake.
  task automatic collect(input bit rnd_ready,
                         input bit rnd_start,
                         input string tag);
    logic [5:0] got[$];
    logic [3:0] tot;
    bit seen;
    seen = 0;
    for (int k = 0; k < 800 && !seen; k++) begin
      ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (valid && ready) got.push_back({A, B});
      tick();
      if (done) seen = 1;
    end
    start = 1'b0;
    ready = 1'b1;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_busy_in_done"}, busy, 0);
    chk({tag, "_valid_in_done"}, valid, 0);
    tot = total;
    compare(tag, got, 63, tot);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_total_hold"}, total, tot);
  endtask

  initial begin
    logic [5:0] g25[$];
    logic [5:0] g7[$];
    logic [3:0] tt25, tt7;
    int  nsol;
    bit  hit4, s25, s7;

    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    st25  = 1'b0;
    st7   = 1'b0;
    #12;
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_total", total, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // latency and stall on first solution
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_busy_c1", busy, 1);
    chk("lat_valid_c1", valid, 0);
    tick();
    chk("lat_valid_c2", valid, 0);
    tick();
    chk("lat_valid_c3", valid, 1);
    chk("lat_A_c3", A, 0);
    chk("lat_B_c3", B, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall_valid_%0d", i), valid, 1);
      chk($sformatf("stall_AB_%0d", i), {A, B}, 6'd1);
      chk($sformatf("stall_total_%0d", i), total, 0);
    end
    collect(1'b1, 1'b0, "sweep_rndready");

    // start noise during the sweep must not disturb it
    start = 1'b1;
    tick();
    collect(1'b1, 1'b1, "sweep_rndstart");

    // reset during HOLD of the fourth solution
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    nsol  = 0;
    hit4  = 0;
    for (int k = 0; k < 300 && !hit4; k++) begin
      if (valid) begin
        nsol++;
        if (nsol == 4) hit4 = 1;
        else begin
          ready = 1'b1;
          tick();
          ready = 1'b0;
        end
      end else begin
        tick();
      end
    end
    chk("r4_reached", hit4, 1);
    chk("r4_AB", {A, B}, {3'd1, 3'd1});
    chk("r4_total", total, exp_total(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("r4_async_A", A, 0);
    chk("r4_async_B", B, 0);
    chk("r4_async_valid", valid, 0);
    chk("r4_async_busy", busy, 0);
    chk("r4_async_total", total, 0);
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(1'b0, 1'b0, "sweep_after_rst");

    // short sweeps, ready tied high
    st25 = 1'b1;
    st7  = 1'b1;
    tick();
    st25 = 1'b0;
    st7  = 1'b0;
    s25 = 0;
    s7  = 0;
    tt25 = '0;
    tt7  = '0;
    for (int k = 0; k < 300 && !(s25 && s7); k++) begin
      if (v25) g25.push_back({a25, b25});
      if (v7) g7.push_back({a7, b7});
      tick();
      if (d25 && !s25) begin s25 = 1; tt25 = t25; end
      if (d7 && !s7) begin s7 = 1; tt7 = t7; end
    end
    chk("l25_done_seen", s25, 1);
    chk("l7_done_seen", s7, 1);
    compare("l25", g25, 25, tt25);
    compare("l7", g7, 7, tt7);
    if (g25.size() > 0)
      chk("l25_last_sol", g25[g25.size() - 1], {3'd3, 3'd1});
    else
      chk("l25_last_sol", 0, {3'd3, 3'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
